// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED request scheduler.
// Pattern encodings, FSM state encoding and the pattern-to-LED mapping.
package led_sched_pkg;

    // Two-bit pattern code a requester asks the LEDs to show.
    typedef enum logic [1:0] {
        OFF   = 2'b00,
        ON    = 2'b01,
        BLINK = 2'b10,
        ALT   = 2'b11
    } led_pat_e;

    // Scheduler states: no owner, owner inside its minimum hold, owner past hold.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        OWN  = 2'b10
    } sched_state_e;

    // Map a pattern code and the current blink phase onto the two LED pins.
    function automatic logic [1:0] pat_to_led(input led_pat_e pat, input logic ph);
        logic [1:0] led_v;
        case (pat)
            OFF:     led_v = 2'b00;
            ON:      led_v = 2'b11;
            BLINK:   led_v = {ph, ph};
            default: led_v = {ph, ~ph};
        endcase
        return led_v;
    endfunction

endpackage

// File: rtl/led_blink_phase.sv
// Blink phase generator: counts 0..BLINK_DIV-1 and toggles ph on each wrap.
// clr restarts the count with ph=1 so a fresh indication starts lit;
// en gates counting. Used by led_req_sched.
module led_blink_phase #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clr,
    input  logic en,
    output logic ph
);
    localparam int CNT_W = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic             ph_q;

    // Phase counter: clear on new grant, otherwise count and toggle ph on wrap.
    always_ff @(posedge sys_clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples pre-edge values; blocking here would create order-dependent races.
        if (sys_rst) begin
            cnt_q <= '0;
            ph_q  <= 1'b1;
        end else if (clr) begin
            cnt_q <= '0;
            ph_q  <= 1'b1;
        end else if (en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_q <= '0;
                ph_q  <= ~ph_q;
            end else begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    assign ph = ph_q;

endmodule

// File: rtl/led_req_sched.sv
// LED request scheduler: fixed-priority arbitration of NUM_REQ requesters for
// the two user LEDs, with a minimum ownership hold and per-owner pattern.
// Optional feature macro: LED_HEARTBEAT_EN -- when defined, IDLE shows an
// alternating heartbeat from the free-running phase counter; when undefined,
// IDLE drives the LEDs off and the phase counter is parked.
module led_req_sched
    import led_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BLINK_DIV = 25000000,
    parameter int MIN_HOLD  = 12500000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] pattern,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic [1:0]           led
);
    localparam int HOLD_W = $clog2(MIN_HOLD + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(MIN_HOLD - 1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
    localparam logic [NUM_REQ-1:0] REQ_ONE   = NUM_REQ'(1);

    // Inputs are registered first, so a request sampled at edge N is granted at N+1.
    logic [NUM_REQ-1:0]   req_q;
    logic [2*NUM_REQ-1:0] pattern_q;

    sched_state_e       state_q;
    logic [HOLD_W-1:0]  hold_q;
    led_pat_e           pat_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               busy_q;
    logic [1:0]         led_q;

    logic [NUM_REQ-1:0] win_d;
    led_pat_e           pat_d;
    logic               owner_req;
    logic               higher_req;
    logic               new_grant;
    logic               ph;
    logic               ph_clr;
    logic               ph_en;
    logic [1:0]         idle_led;

    // Fixed-priority arbiter: lowest pending index wins and supplies its pattern.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch,
        // otherwise paths that skip an assignment infer a latch.
        win_d = '0;
        pat_d = OFF;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_q[i]) begin
                win_d    = '0;
                win_d[i] = 1'b1;
                pat_d    = led_pat_e'(pattern_q[2*i +: 2]);
            end
        end
    end

    // grant_q - 1 sets every bit below the one-hot owner, i.e. all higher priorities.
    assign owner_req  = |(req_q & grant_q);
    assign higher_req = |(req_q & (grant_q - REQ_ONE));

    // Decide whether this edge issues a (re)grant; HOLD never grants.
    always_comb begin
        new_grant = 1'b0;
        case (state_q)
            IDLE:    new_grant = |req_q;
            OWN:     new_grant = higher_req || (!owner_req && (|req_q));
            default: new_grant = 1'b0;
        endcase
    end

`ifdef LED_HEARTBEAT_EN
    assign ph_en    = 1'b1;
    assign ph_clr   = new_grant;
    assign idle_led = {ph, ~ph};
`else
    assign ph_en    = (state_q != IDLE);
    assign ph_clr   = new_grant || (state_q == IDLE);
    assign idle_led = 2'b00;
`endif

    led_blink_phase #(
        .BLINK_DIV (BLINK_DIV)
    ) u_phase (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (ph_clr),
        .en      (ph_en),
        .ph      (ph)
    );

    // Scheduler FSM with input sampling, hold counter and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            req_q     <= '0;
            pattern_q <= '0;
            state_q   <= IDLE;
            hold_q    <= '0;
            pat_q     <= OFF;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            led_q     <= 2'b00;
        end else begin
            req_q     <= req;
            pattern_q <= pattern;
            led_q     <= (state_q == IDLE) ? idle_led : pat_to_led(pat_q, ph);

            if (new_grant) begin
                state_q <= HOLD;
                grant_q <= win_d;
                pat_q   <= pat_d;
                hold_q  <= HOLD_LOAD;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    HOLD: begin
                        if (hold_q == '0) begin
                            state_q <= OWN;
                        end else begin
                            hold_q <= hold_q - HOLD_ONE;
                        end
                    end
                    OWN: begin
                        // No regrant and owner gone means nobody is requesting.
                        if (!owner_req) begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign led   = led_q;

endmodule
